fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the synchronous FIFO between NUM_REQ producers. Each producer has a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST words and never drives a write into a full FIFO. It sits between the producer blocks and the FIFO write-side signals (wr_en, data_in, full).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, FIFO word width
MAX_BURST, 4, max consecutive words per grant (1..16)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester word available
req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester word accepted this cycle (when valid also high)
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  FIFO write enable
fifo_data_in  out  DATA_WIDTH  FIFO write data
grant_id  out  $clog2(NUM_REQ)  current owner (valid only while busy)
busy  out  1  a grant is held

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE; rr_ptr = 0; burst_cnt = 0; grant_id = 0; busy = 0.
  - req_ready = 0, fifo_wr_en = 0, fifo_data_in = 0.
- Registered state: state, grant_id, rr_ptr, burst_cnt.
- Combinational outputs:
  - beat = busy & req_valid[grant_id] & ~fifo_full.
  - fifo_wr_en = beat; req_ready[grant_id] = beat; all other req_ready bits = 0.
  - fifo_data_in = req_data slice of grant_id while busy, else 0.
- Round-robin pick: first i with req_valid[i] = 1, searching from rr_ptr upward with wrap at NUM_REQ.
- IDLE state:
  - If any req_valid is high, register the winner into grant_id; burst_cnt = 0; state = GRANT.
  - Arbitration latency is 1 cycle: the first beat can occur the cycle after the request is seen.
- GRANT state (busy = 1):
  - On beat: burst_cnt increments.
  - Release when either:
    - beat occurs and burst_cnt == MAX_BURST-1, or
    - req_valid[grant_id] = 0 (the owner has dropped valid).
  - fifo_full with owner valid: a stall. Grant, burst_cnt and data are held; no timeout.
- On release:
  - rr_ptr = (grant_id+1) mod NUM_REQ.
  - The next winner is picked in the same cycle using the updated rr_ptr, excluding the releasing owner.
  - If a winner exists, it is granted next cycle with burst_cnt = 0 (no IDLE bubble). Otherwise state = IDLE.
  - If the releasing owner is the only requester still valid, it is re-granted (no starvation of a lone requester).
- Fairness: while all requesters are continuously valid, grants rotate 0,1,2,3,0,... with exactly MAX_BURST words each.
- Requester valid is required to stay high until ready; data stable while valid & ~ready. The arbiter does not check this.
- Never: fifo_wr_en = 1 while fifo_full = 1; more than one req_ready bit high; more than MAX_BURST consecutive beats to one owner when others are valid.
- Reset mid-burst: outputs drop in the same cycle. A word presented in that cycle is not accepted. After release, arbitration restarts from rr_ptr = 0.

Decomposition:
- Package fifo_arb_pkg:
  - typedef arb_state_t {IDLE, GRANT}.
  - Default constants NUM_REQ_DEF, DATA_WIDTH_DEF, MAX_BURST_DEF.
  - Function rr_pick(valid, ptr, exclude_en, exclude_id) returning found flag + index.
- Sub-module rr_priority_pick: combinational rotate–priority-encode–unrotate, instantiated once.
- Top level holds the FSM, burst counter and output mux.
- Bench reuses the existing FIFO and FIFO monitor behind the arbiter. A scoreboard keeps a per-requester expected queue and checks FIFO read-side order.

Test Plan:
- Single requester: req_valid=4'b0001, 6 words 0xA000..0xA005, FIFO empty -> first wr_en 1 cycle after valid. Two bursts: words 0–3, then re-grant with no IDLE cycle, then 4–5. Read order matches.
- All four valid continuously, MAX_BURST=4 -> grant_id sequence 0,1,2,3,0 with 4 beats each, no bubbles, one req_ready bit max.
- FIFO full mid-burst: requester 2 at burst_cnt=2, fifo_full=1 for 5 cycles -> wr_en=0 for 5 cycles, grant_id stays 2. Resumes and ends after 2 more words.
- Early drop: requester 1 writes 2 words then deasserts valid while 3 is valid -> release, grant_id=3 next cycle, rr_ptr=2.
- rst asserted while busy with wr_en high -> wr_en, req_ready, busy go 0 before next edge. After deassert, request from 1 and 0 together -> grant_id=0.
- Back-to-back full/empty: fill FIFO to full via requesters 0 and 3 -> no write while full, no lost or duplicated word per scoreboard.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and the round-robin pick function for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned MAX_BURST_DEF  = 4;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Works on up to 8 requesters; entries at or above num are ignored.
  function automatic rr_pick_t rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                       input logic exclude_en, input logic [2:0] exclude_id,
                                       input logic [3:0] num);
    logic [7:0] masked;
    logic [7:0] rot;
    logic [3:0] src;
    logic [3:0] sum;
    logic [2:0] off;
    rr_pick_t   res;
    masked = valid;
    if (exclude_en) masked[exclude_id] = 1'b0;
    rot = '0;
    for (int k = 0; k < 8; k++) begin
      src = {1'b0, ptr} + 4'(k);
      if (src >= num) src = src - num;
      if (4'(k) < num) rot[k] = masked[src[2:0]];
    end
    off       = '0;
    res.found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (rot[k]) begin
        res.found = 1'b1;
        off       = 3'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= num) sum = sum - num;
    res.idx = sum[2:0];
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational round-robin winner select: rotate by ptr, priority-encode, rotate back.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IdW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IdW-1:0]     ptr,
  input  logic               exclude_en,
  input  logic [IdW-1:0]     exclude_id,
  output logic               found,
  output logic [IdW-1:0]     idx
);

  rr_pick_t res;

  always_comb begin
    res   = rr_pick(8'(valid), 3'(ptr), exclude_en, 3'(exclude_id), 4'(NUM_REQ));
    found = res.found;
    idx   = IdW'(res.idx);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers,
// with bursts of at most MAX_BURST words per grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MAX_BURST  = MAX_BURST_DEF,
  localparam int unsigned IdW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IdW-1:0]                grant_id,
  output logic                          busy
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);
  localparam logic [IdW-1:0]  LastId   = IdW'(NUM_REQ - 1);

  arb_state_t      state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] burst_q, burst_d;
  logic [IdW-1:0]  next_ptr, pick_ptr, pick_idx;
  logic            pick_found, owner_valid, beat, release_grant;

  assign busy          = (state_q == GRANT);
  assign grant_id      = grant_q;
  assign owner_valid   = req_valid[grant_q];
  assign beat          = busy & owner_valid & ~fifo_full;
  assign fifo_wr_en    = beat;
  assign next_ptr      = (grant_q == LastId) ? '0 : grant_q + 1'b1;
  assign pick_ptr      = busy ? next_ptr : rr_ptr_q;
  assign release_grant = busy & ((beat & (burst_q == LastBeat)) | ~owner_valid);

  // While granted, the search starts past the owner so the owner only wins when alone.
  rr_priority_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (pick_ptr),
    .exclude_en(busy),
    .exclude_id(grant_q),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (busy && grant_q == IdW'(i)) begin
        req_ready[i] = beat;
        fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (beat) burst_d = burst_q + 1'b1;
        if (release_grant) begin
          rr_ptr_d = next_ptr;
          burst_d  = '0;
          if (pick_found) grant_d = pick_idx;
          else if (!owner_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic
// against a transaction-level arbiter model with a FIFO order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  int total = 0;
  int bad = 0;

  logic [N-1:0]  pv;
  logic [DW-1:0] pw [N];
  logic [DW-1:0] src_q [N][$];
  bit            use_prod, force_full;
  int            vprob, rd_prob;
  bit            m_busy;
  int            m_owner, m_cnt, m_ptr;
  logic [DW-1:0] fq [$];
  logic [DW-1:0] eq [$];
  logic          cap_wr, cap_busy;
  logic [N-1:0]  cap_rdy;
  logic [DW-1:0] cap_din;
  logic [1:0]    cap_gid;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        full;
    logic        wr;
    logic        bsy;
    logic [15:0] dout;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input int p);
    for (int k = 0; k < N; k++) begin
      if (pv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    fq.delete(); eq.delete();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      pw[i] = '0;
    end
    pv = '0;
    force_full = 0;
  endtask

  task automatic prod_refresh();
    for (int i = 0; i < N; i++) begin
      if (!pv[i] && src_q[i].size() > 0 && int'($urandom_range(0, 99)) < vprob) begin
        pv[i] = 1'b1;
        pw[i] = src_q[i][0];
      end
    end
  endtask

  task automatic load(input int id, input int cnt);
    for (int k = 0; k < cnt; k++) src_q[id].push_back({4'(id), 12'($urandom)});
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pw[i];
    req_valid = pv;
    fifo_full = force_full || (fq.size() >= DEPTH);
  endtask

  task automatic tick();
    bit eb;
    int nxt;
    logic [DW-1:0] w;
    @(negedge clk);
    drive_inputs();
    #1;
    eb = m_busy && pv[m_owner] && !fifo_full;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("wr_en", 32'(fifo_wr_en), 32'(eb));
    chk("ready", 32'(req_ready), eb ? (32'd1 << m_owner) : 32'd0);
    if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("data", 32'(fifo_data_in), m_busy ? 32'(pw[m_owner]) : 32'd0);
    cap_wr = fifo_wr_en; cap_busy = busy; cap_rdy = req_ready;
    cap_din = fifo_data_in; cap_gid = grant_id;
    if (!m_busy) begin
      nxt = first_from(m_ptr);
      if (nxt >= 0) begin
        m_busy = 1; m_owner = nxt; m_cnt = 0;
      end
    end else begin
      if (eb) begin
        eq.push_back(pw[m_owner]);
        m_cnt++;
      end
      if ((eb && m_cnt == MB) || !pv[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        nxt = first_from(m_ptr);  // owner sits last in the circle
        if (nxt >= 0) begin
          m_owner = nxt; m_cnt = 0;
        end else m_busy = 0;
      end
    end
    @(posedge clk);
    if (cap_wr) fq.push_back(cap_din);
    if (fq.size() > 0 && int'($urandom_range(0, 99)) < rd_prob) begin
      w = fq.pop_front();
      if (eq.size() == 0) begin
        total++; bad++;
        $display("FAIL fifo_extra: got %0h expected no word", w);
      end else chk("fifo_order", 32'(w), 32'(eq.pop_front()));
    end
    if (use_prod) begin
      for (int i = 0; i < N; i++) begin
        if (pv[i] && cap_rdy[i]) begin
          void'(src_q[i].pop_front());
          pv[i] = 1'b0;
          pw[i] = '0;
        end
      end
      prod_refresh();
    end
  endtask

  task automatic hw_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    fifo_full = 1'b0;
    req_data = {$urandom, $urandom};
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(fifo_wr_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", 32'(fifo_data_in), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    model_reset();
    vprob = 100; rd_prob = 100; use_prod = 1;
  endtask

  task automatic drain();
    int left;
    rd_prob = 100; vprob = 100; force_full = 0;
    for (int k = 0; k < 400; k++) begin
      left = fq.size();
      for (int i = 0; i < N; i++) left += src_q[i].size();
      if (left == 0 && !m_busy) break;
      tick();
    end
    left = fq.size();
    for (int i = 0; i < N; i++) left += src_q[i].size();
    chk("drain_left", 32'(left), 32'd0);
    chk("drain_exp", 32'(eq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 16'hA000, 1'b0, 1'b1, 1'b1, 16'hA000};
    tbl[2] = '{1'b1, 16'hA001, 1'b0, 1'b1, 1'b1, 16'hA001};
    tbl[3] = '{1'b1, 16'hA002, 1'b0, 1'b1, 1'b1, 16'hA002};
    tbl[4] = '{1'b1, 16'hA003, 1'b0, 1'b1, 1'b1, 16'hA003};
    tbl[5] = '{1'b1, 16'hA004, 1'b0, 1'b1, 1'b1, 16'hA004};
    tbl[6] = '{1'b1, 16'hA005, 1'b1, 1'b0, 1'b1, 16'hA005};
    tbl[7] = '{1'b1, 16'hA005, 1'b0, 1'b1, 1'b1, 16'hA005};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

    // Single requester: 4-word burst, gapless re-grant, one full stall, release.
    hw_reset();
    use_prod = 0;
    for (int r = 0; r < 10; r++) begin
      pv = {3'b000, tbl[r].v};
      pw[0] = tbl[r].d;
      force_full = tbl[r].full;
      tick();
      chk("tbl_wr", 32'(cap_wr), 32'(tbl[r].wr));
      chk("tbl_busy", 32'(cap_busy), 32'(tbl[r].bsy));
      chk("tbl_dout", 32'(cap_din), 32'(tbl[r].dout));
      chk("tbl_ready", 32'(cap_rdy), 32'(tbl[r].wr));
    end
    drain();

    // All four continuously valid: 0,1,2,3,0.. with MB beats each, no bubbles.
    hw_reset();
    for (int i = 0; i < N; i++) load(i, 8);
    prod_refresh();
    tick();
    chk("fair_first", 32'(cap_wr), 32'd0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("fair_wr", 32'(cap_wr), 32'd1);
      chk("fair_gid", 32'(cap_gid), 32'((k / MB) % N));
      chk("fair_onehot", 32'($countones(cap_rdy)), 32'd1);
    end
    drain();

    // FIFO full mid-burst for requester 2 at burst count 2.
    hw_reset();
    load(2, 4);
    prod_refresh();
    repeat (3) tick();
    force_full = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_wr", 32'(cap_wr), 32'd0);
      chk("stall_gid", 32'(cap_gid), 32'd2);
    end
    force_full = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("resume_wr", 32'(cap_wr), 32'd1);
    end
    tick();
    chk("resume_end", 32'(cap_wr), 32'd0);
    drain();

    // Requester 1 drops after 2 words while 3 waits.
    hw_reset();
    load(1, 2);
    load(3, 3);
    prod_refresh();
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("drop_gid1", 32'(cap_gid), 32'd1);
    end
    tick();
    chk("drop_rel_wr", 32'(cap_wr), 32'd0);
    tick();
    chk("drop_gid3", 32'(cap_gid), 32'd3);
    chk("drop_wr3", 32'(cap_wr), 32'd1);
    drain();

    // Reset while a beat is on the bus.
    hw_reset();
    load(2, 3);
    prod_refresh();
    tick();
    @(negedge clk);
    drive_inputs();
    #1;
    chk("pre_rst_wr", 32'(fifo_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", 32'(fifo_wr_en), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    model_reset();
    load(0, 2);
    load(1, 2);
    prod_refresh();
    tick();
    tick();
    chk("post_rst_gid", 32'(cap_gid), 32'd0);
    drain();

    // Fill the FIFO from requesters 0 and 3, hold full, then drain.
    hw_reset();
    load(0, 10);
    load(3, 10);
    prod_refresh();
    rd_prob = 0;
    repeat (20) tick();
    chk("full_level", 32'(fq.size()), 32'(DEPTH));
    rd_prob = 35;
    repeat (60) tick();
    drain();

    // Random traffic with sporadic external full.
    hw_reset();
    for (int i = 0; i < N; i++) load(i, 40);
    vprob = 40;
    prod_refresh();
    for (int k = 0; k < 600; k++) begin
      rd_prob = int'($urandom_range(20, 80));
      force_full = ($urandom_range(0, 9) == 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
